// File: rtl/bitmanip_if.sv
// Request/response bundle between the CPU and the bit-manipulation unit.
// The CPU drives the master side; the unit implements the slave side.
interface bitmanip_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand;
  logic             clr;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output start, op, operand, clr,
    input  busy, done, result, zero
  );

  modport slave (
    input  start, op, operand, clr,
    output busy, done, result, zero
  );
endinterface

// File: rtl/bitmanip_unit.sv
// Multi-cycle bit-manipulation unit: REV / POPCNT / CLZ / CTZ over a WIDTH-bit
// operand, consuming STEP bits per RUN cycle, least significant chunk first.
module bitmanip_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 4
) (
  input logic      clk,
  input logic      rst,
  bitmanip_if.slave bus
);
  localparam int unsigned N  = WIDTH / STEP;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] LAST = KW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [1:0]       op_q, op_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             found_q, found_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic [STEP-1:0]  chunk, chunk_rev;
  logic [CW-1:0]    chunk_pop, chunk_lz, chunk_tz;
  logic [WIDTH-1:0] res_fin;

  always_comb begin
    chunk     = opnd_q[STEP-1:0];
    chunk_rev = '0;
    chunk_pop = '0;
    chunk_lz  = CW'(STEP);
    chunk_tz  = CW'(STEP);
    for (int unsigned i = 0; i < STEP; i++) begin
      chunk_rev[i] = chunk[STEP-1-i];
      chunk_pop    = chunk_pop + CW'(chunk[i]);
      // ascending scan: last hit is the highest set bit
      if (chunk[i]) chunk_lz = CW'(STEP - 1 - i);
      // descending scan: last hit is the lowest set bit
      if (chunk[STEP-1-i]) chunk_tz = CW'(STEP - 1 - i);
    end
  end

  always_comb begin
    state_d  = state_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    k_d      = k_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    found_d  = found_q;
    result_d = result_q;
    zero_d   = zero_q;
    res_fin  = '0;

    unique case (state_q)
      S_RUN: begin
        opnd_d = opnd_q >> STEP;
        k_d    = k_q + KW'(1);
        // Chunks arrive LSB first; CLZ tracks leading zeros of the prefix seen so far.
        unique case (op_q)
          2'b00: acc_d = (acc_q << STEP) | WIDTH'(chunk_rev);
          2'b01: cnt_d = cnt_q + chunk_pop;
          2'b10: cnt_d = (chunk == '0) ? cnt_q + CW'(STEP) : chunk_lz;
          2'b11: if (!found_q) begin
                   cnt_d   = cnt_q + chunk_tz;
                   found_d = |chunk;
                 end
          default: ;
        endcase
        res_fin = (op_q == 2'b00) ? acc_d : WIDTH'(cnt_d);
        if (k_q == LAST) begin
          state_d  = S_DONE;
          result_d = res_fin;
          zero_d   = (res_fin == '0);
        end
      end
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          state_d = S_RUN;
          opnd_d  = bus.operand;
          op_d    = bus.op;
          k_d     = '0;
          acc_d   = '0;
          cnt_d   = '0;
          found_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.clr) begin
      state_d  = S_IDLE;
      result_d = result_q;
      zero_d   = zero_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      opnd_q   <= '0;
      op_q     <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      found_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      found_q  <= found_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.busy   = (state_q == S_RUN);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;
  assign bus.zero   = zero_q;
endmodule

// File: tb/tb_bitmanip_unit.sv
// Directed bench for bitmanip_unit: a 16/4 instance and an 8/1 instance.
module tb_bitmanip_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bitmanip_if #(.WIDTH(16)) a ();
  bitmanip_if #(.WIDTH(8))  b ();

  bitmanip_unit #(.WIDTH(16), .STEP(4)) dut_a (.clk(clk), .rst(rst), .bus(a));
  bitmanip_unit #(.WIDTH(8),  .STEP(1)) dut_b (.clk(clk), .rst(rst), .bus(b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done_a(output int n, output int nb);
    n = 0; nb = 0;
    while (a.done !== 1'b1 && n < 50) begin
      if (a.busy === 1'b1) nb++;
      tick();
      n++;
    end
  endtask

  task automatic do_op_a(input string tag, input logic [1:0] o, input logic [15:0] v,
                         input logic [15:0] exp, input logic expz);
    int n, nb;
    a.op = o; a.operand = v; a.start = 1'b1;
    tick();
    a.start = 1'b0;
    a.operand = ~v;
    chk({tag, "_busy"}, a.busy, 1);
    wait_done_a(n, nb);
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_busycyc"}, nb, 4);
    chk({tag, "_res"}, a.result, exp);
    chk({tag, "_zero"}, a.zero, expz);
    chk({tag, "_nobusy"}, a.busy, 0);
    tick();
    chk({tag, "_idle_done"}, a.done, 0);
    chk({tag, "_hold"}, a.result, exp);
  endtask

  task automatic do_op_b(input string tag, input logic [1:0] o, input logic [7:0] v,
                         input logic [7:0] exp);
    int n, nb;
    b.op = o; b.operand = v; b.start = 1'b1;
    tick();
    b.start = 1'b0;
    n = 0; nb = 0;
    while (b.done !== 1'b1 && n < 50) begin
      if (b.busy === 1'b1) nb++;
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, 8);
    chk({tag, "_busycyc"}, nb, 8);
    chk({tag, "_res"}, b.result, exp);
    chk({tag, "_zero"}, b.zero, 0);
    tick();
    chk({tag, "_idle"}, b.done, 0);
  endtask

  initial begin
    int n, nb;
    logic saw_done;
    a.start = 1'b0; a.op = 2'b00; a.operand = '0; a.clr = 1'b0;
    b.start = 1'b0; b.op = 2'b00; b.operand = '0; b.clr = 1'b0;

    #2 rst = 1'b0;
    #1;
    chk("rst_busy", a.busy, 0);
    chk("rst_done", a.done, 0);
    chk("rst_result", a.result, 16'h0000);
    chk("rst_zero", a.zero, 1);
    #10 rst = 1'b1;
    tick();

    do_op_a("rev1",   2'b00, 16'h0001, 16'h8000, 1'b0);
    do_op_a("pop",    2'b01, 16'hF0F1, 16'h0009, 1'b0);
    do_op_a("rev2",   2'b00, 16'hB2C4, 16'h234D, 1'b0);
    repeat (3) tick();
    chk("rev2_hold_long", a.result, 16'h234D);
    do_op_a("clz",    2'b10, 16'h0010, 16'd11, 1'b0);
    do_op_a("ctz",    2'b11, 16'h0100, 16'd8,  1'b0);
    do_op_a("clz0",   2'b10, 16'h0000, 16'd16, 1'b0);
    do_op_a("ctz0",   2'b11, 16'h0000, 16'd16, 1'b0);
    do_op_a("pop0",   2'b01, 16'h0000, 16'h0000, 1'b1);

    // back-to-back with start held high
    a.op = 2'b01; a.operand = 16'h0003; a.start = 1'b1;
    tick();
    a.operand = 16'h0007;
    wait_done_a(n, nb);
    chk("b2b_lat1", n, 4);
    chk("b2b_res1", a.result, 16'd2);
    tick();
    chk("b2b_reaccept_busy", a.busy, 1);
    chk("b2b_reaccept_done", a.done, 0);
    chk("b2b_res_held", a.result, 16'd2);
    a.operand = 16'hFFFF;
    tick();
    tick();
    a.start = 1'b0;
    n = 3;
    while (a.done !== 1'b1 && n < 50) begin tick(); n++; end
    chk("b2b_period", n, 5);
    chk("b2b_res2", a.result, 16'd3);
    tick();
    chk("b2b_idle", a.busy, 0);

    // async reset during the second RUN cycle
    a.op = 2'b00; a.operand = 16'h0001; a.start = 1'b1;
    tick();
    a.start = 1'b0;
    tick();
    chk("mid_busy", a.busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", a.busy, 0);
    chk("arst_done", a.done, 0);
    chk("arst_result", a.result, 16'h0000);
    chk("arst_zero", a.zero, 1);
    #1 rst = 1'b1;
    saw_done = 1'b0;
    repeat (6) begin tick(); if (a.done === 1'b1) saw_done = 1'b1; end
    chk("arst_no_done", saw_done, 0);

    // clr with start during RUN
    do_op_a("pre_clr", 2'b01, 16'hF0F1, 16'h0009, 1'b0);
    a.op = 2'b00; a.operand = 16'h0001; a.start = 1'b1;
    tick();
    a.start = 1'b0;
    tick();
    a.clr = 1'b1; a.start = 1'b1;
    tick();
    a.clr = 1'b0; a.start = 1'b0;
    chk("clr_busy", a.busy, 0);
    chk("clr_done", a.done, 0);
    chk("clr_result", a.result, 16'h0009);
    saw_done = 1'b0;
    repeat (6) begin tick(); if (a.done === 1'b1 || a.busy === 1'b1) saw_done = 1'b1; end
    chk("clr_no_done", saw_done, 0);
    chk("clr_result_kept", a.result, 16'h0009);

    // 8-bit, one bit per cycle
    do_op_b("w8_rev", 2'b00, 8'h01, 8'h80);
    do_op_b("w8_clz0", 2'b10, 8'h00, 8'h08);
    do_op_b("w8_ctz", 2'b11, 8'h28, 8'h03);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
